dport_sim_ctrl: RTL and testbench
=================================

DPORT_SIM_CTRL -- requirements
Module: dport_sim_ctrl

Interface
REQ-001 SHALL have parameter: BASE_ADDR, 32'h90000000, base of the 256-byte register window; decode compares mem_d_addr_i[31:8] with BASE_ADDR[31:8].
REQ-002 SHALL have ports: clk_i  input  1  clock; all state on rising edge.
REQ-003 SHALL have ports: rst_i  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have ports: mem_d_addr_i  input  32  request byte address.
REQ-005 SHALL have ports: mem_d_data_wr_i  input  32  write data.
REQ-006 SHALL have ports: mem_d_rd_i  input  1  read request.
REQ-007 SHALL have ports: mem_d_wr_i  input  4  byte-enable write request.
REQ-008 SHALL have ports: mem_d_cacheable_i, mem_d_invalidate_i, mem_d_writeback_i, mem_d_flush_i  input  1 each  cache maintenance hints.
REQ-009 SHALL have ports: mem_d_req_tag_i  input  11  request tag.
REQ-010 SHALL have ports: mem_d_data_rd_o  output  32  read data, valid with ack.
REQ-011 SHALL have ports: mem_d_accept_o  output  1  request accepted this cycle.
REQ-012 SHALL have ports: mem_d_ack_o  output  1  response valid.
REQ-013 SHALL have ports: mem_d_error_o  output  1  response error, valid with ack.
REQ-014 SHALL have ports: mem_d_resp_tag_o  output  11  echoed tag.
REQ-015 SHALL have ports: console_valid_o  output  1, console_data_o  output  8, console_ready_i  input  1  console byte stream.
REQ-016 SHALL have ports: done_o  output  1, pass_o  output  1  test status.

Function
REQ-017 SHALL treat a request as present when mem_d_rd_i or any mem_d_wr_i bit or any maintenance hint is set; when both read and write are set, SHALL execute the write.
REQ-018 SHALL accept (mem_d_accept_o=1) in the same cycle as the request, except for a CONSOLE write while the TX FIFO is full.
REQ-019 SHALL assert mem_d_ack_o for exactly one cycle, on the cycle after acceptance, with mem_d_resp_tag_o equal to the accepted tag; latency is fixed at 1 and back-to-back requests SHALL get back-to-back acks.
REQ-020 Register map, offset = addr[7:0]: 0x00 STATUS RW {30'b0,pass,done}; 0x04 CYCLE RO; 0x08 SCRATCH RW; 0x0C CONSOLE (write pushes data[7:0] when wr[0] is set; read returns {29'b0,count[2:0]}).
REQ-021 SHALL apply byte enables to SCRATCH; SHALL ignore byte enables on other registers, except that CONSOLE requires wr[0].
REQ-022 STATUS: a write with data[0]=1 SHALL set done and load pass=data[1]; both bits are sticky until reset, and later writes are ignored.
REQ-023 CYCLE SHALL increment every clock from 0, wrapping 0xFFFFFFFF->0; writes are acked without error and have no effect.
REQ-024 Out-of-window or unmapped offset, and misaligned access (addr[1:0]!=0): SHALL ack with mem_d_error_o=1, mem_d_data_rd_o=0, and no state change.
REQ-025 Maintenance-hint-only requests SHALL be acked with error=0 and data 0, with no effect.
REQ-026 TX FIFO: 4 entries, FIFO order; console_valid_o=!empty; pop when console_valid_o && console_ready_i.
REQ-027 mem_d_accept_o SHALL depend only on registered FIFO count; a full FIFO with a same-cycle pop still stalls that cycle. A simultaneous push and pop on a non-full FIFO SHALL keep the count unchanged.
REQ-028 mem_d_data_rd_o SHALL be 0 when mem_d_ack_o=0.

Reset
REQ-029 On rst_i: all outputs 0, CYCLE=0, SCRATCH=0, STATUS=0, FIFO empty.
REQ-030 Reset mid-operation SHALL drop any pending ack; no ack is issued after reset release for a pre-reset request.

Configuration
REQ-031 With DPORT_SIM_CTRL_CONSOLE_EN defined, the TX FIFO and console port SHALL be as in REQ-026/027.
REQ-032 Without DPORT_SIM_CTRL_CONSOLE_EN, CONSOLE writes SHALL be acked and discarded, reads return 0, console_valid_o=0, console_data_o=0, and mem_d_accept_o SHALL be constant 1.

Verification
REQ-033 Write SCRATCH 0x11223344 with wr=4'b0011, then write 0xAABBCCDD with wr=4'b1100, then read -> data 0xAABB3344; each ack comes 1 cycle after accept with the matching tag.
REQ-034 Write STATUS 0x3 -> done_o=1, pass_o=1; then write 0x1 -> unchanged; read -> 0x3.
REQ-035 Hold console_ready_i=0 and write CONSOLE 5 times ('A'..'E') -> first 4 accepted, 5th stalls with accept=0; raise ready -> bytes 'A','B','C','D','E' emitted in order and the 5th accepted one cycle after the first pop.
REQ-036 Read 0x90000100, read 0x9000001C, read 0x90000002 -> each acked with error=1, data 0; no state change.
REQ-037 Read CYCLE twice, 10 cycles apart -> difference 10; force counter to 0xFFFFFFFF -> next value 0.
REQ-038 Assert rst_i the cycle after accepting a read -> no ack is seen and all outputs are 0.

Source files
------------

// File: rtl/dport_sim_ctrl.sv
// dport_sim_ctrl: memory-mapped simulation control block (status, cycle counter, scratch, console TX FIFO); console FIFO enabled by DPORT_SIM_CTRL_CONSOLE_EN
module dport_sim_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h9000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] mem_d_addr_i,
  input  logic [31:0] mem_d_data_wr_i,
  input  logic        mem_d_rd_i,
  input  logic [3:0]  mem_d_wr_i,
  input  logic        mem_d_cacheable_i,
  input  logic        mem_d_invalidate_i,
  input  logic        mem_d_writeback_i,
  input  logic        mem_d_flush_i,
  input  logic [10:0] mem_d_req_tag_i,
  output logic [31:0] mem_d_data_rd_o,
  output logic        mem_d_accept_o,
  output logic        mem_d_ack_o,
  output logic        mem_d_error_o,
  output logic [10:0] mem_d_resp_tag_o,
  output logic        console_valid_o,
  output logic [7:0]  console_data_o,
  input  logic        console_ready_i,
  output logic        done_o,
  output logic        pass_o
);
  logic [31:0] cycle_q, cycle_nxt, scratch_q, data_q, rd_data, con_rd;
  logic [10:0] tag_q;
  logic        done_q, pass_q, ack_q, err_q;
  logic        is_wr, req, hint_only, bad, wr_ok, fire;
  logic [1:0]  off;
  assign is_wr     = |mem_d_wr_i;
  assign req       = mem_d_rd_i | is_wr | mem_d_cacheable_i | mem_d_invalidate_i | mem_d_writeback_i | mem_d_flush_i;
  assign hint_only = !mem_d_rd_i && !is_wr;
  assign bad       = (mem_d_addr_i[31:8] != BASE_ADDR[31:8]) || (mem_d_addr_i[1:0] != 2'd0) || (mem_d_addr_i[7:4] != 4'd0);
  assign off       = mem_d_addr_i[3:2];
  assign wr_ok     = is_wr && !bad;
  assign fire      = req && mem_d_accept_o;
  assign cycle_nxt = cycle_q + 32'd1;
`ifdef DPORT_SIM_CTRL_CONSOLE_EN
  logic [7:0] fifo_q [4];
  logic [1:0] wr_ptr_q, rd_ptr_q;
  logic [2:0] count_q;
  logic       con_wr, push, pop;
  assign con_wr          = wr_ok && off == 2'd3 && mem_d_wr_i[0];
  assign mem_d_accept_o  = !rst_i && !(con_wr && count_q[2]);
  assign push            = fire && con_wr;
  assign pop             = console_valid_o && console_ready_i;
  assign console_valid_o = count_q != 3'd0;
  assign console_data_o  = console_valid_o ? fifo_q[rd_ptr_q] : 8'd0;
  assign con_rd          = {29'd0, count_q};
  // FIFO pointers and occupancy; push and pop in one cycle leave the count unchanged
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      wr_ptr_q <= wr_ptr_q + {1'b0, push};
      rd_ptr_q <= rd_ptr_q + {1'b0, pop};
      count_q  <= count_q + {2'd0, push} - {2'd0, pop};
    end
  // FIFO storage needs no reset; output is masked while empty
  always_ff @(posedge clk_i)
    if (push) fifo_q[wr_ptr_q] <= mem_d_data_wr_i[7:0];
`else
  assign mem_d_accept_o  = !rst_i;
  assign console_valid_o = 1'b0;
  assign console_data_o  = 8'd0;
  assign con_rd          = 32'd0;
`endif
  // read mux; writes, hints and errored requests return zero
  always_comb
    rd_data = (hint_only || bad || is_wr) ? 32'd0 :
              off == 2'd0 ? {30'd0, pass_q, done_q} :
              off == 2'd1 ? cycle_q :
              off == 2'd2 ? scratch_q : con_rd;
  // registers and one-cycle response pipeline
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      cycle_q   <= 32'd0;
      scratch_q <= 32'd0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      tag_q     <= 11'd0;
      data_q    <= 32'd0;
    end else begin
      cycle_q <= cycle_nxt;
      ack_q   <= fire;
      err_q   <= fire && !hint_only && bad;
      tag_q   <= fire ? mem_d_req_tag_i : 11'd0;
      data_q  <= fire ? rd_data : 32'd0;
      if (fire && wr_ok && off == 2'd2)
        for (int i = 0; i < 4; i++)
          if (mem_d_wr_i[i]) scratch_q[8*i +: 8] <= mem_d_data_wr_i[8*i +: 8];
      if (fire && wr_ok && off == 2'd0 && !done_q && mem_d_data_wr_i[0]) begin
        done_q <= 1'b1;
        pass_q <= mem_d_data_wr_i[1];
      end
    end
  assign mem_d_data_rd_o  = data_q;
  assign mem_d_ack_o      = ack_q;
  assign mem_d_error_o    = err_q;
  assign mem_d_resp_tag_o = tag_q;
  assign done_o           = done_q;
  assign pass_o           = pass_q;
endmodule

// File: tb/tb_dport_sim_ctrl.sv
// tb_dport_sim_ctrl: directed scoreboard bench for dport_sim_ctrl
module tb_dport_sim_ctrl;
  localparam logic [31:0] B = 32'h9000_0000;
  logic        clk_i = 1'b0, rst_i = 1'b1;
  logic [31:0] mem_d_addr_i = '0, mem_d_data_wr_i = '0, mem_d_data_rd_o;
  logic        mem_d_rd_i = 1'b0;
  logic [3:0]  mem_d_wr_i = '0;
  logic        mem_d_cacheable_i = 1'b0, mem_d_invalidate_i = 1'b0, mem_d_writeback_i = 1'b0, mem_d_flush_i = 1'b0;
  logic [10:0] mem_d_req_tag_i = '0, mem_d_resp_tag_o;
  logic        mem_d_accept_o, mem_d_ack_o, mem_d_error_o;
  logic        console_valid_o, console_ready_i = 1'b0, done_o, pass_o;
  logic [7:0]  console_data_o;
  typedef struct {logic [10:0] tag; logic err; logic [31:0] data;} exp_t;
  exp_t        sb[$];
  logic [7:0]  cq[$];
  int          compared = 0, mismatched = 0;
  logic [10:0] tag_n = 11'd1;
  logic [31:0] cyc_m, c0;

  dport_sim_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .mem_d_addr_i(mem_d_addr_i), .mem_d_data_wr_i(mem_d_data_wr_i),
    .mem_d_rd_i(mem_d_rd_i), .mem_d_wr_i(mem_d_wr_i), .mem_d_cacheable_i(mem_d_cacheable_i),
    .mem_d_invalidate_i(mem_d_invalidate_i), .mem_d_writeback_i(mem_d_writeback_i),
    .mem_d_flush_i(mem_d_flush_i), .mem_d_req_tag_i(mem_d_req_tag_i), .mem_d_data_rd_o(mem_d_data_rd_o),
    .mem_d_accept_o(mem_d_accept_o), .mem_d_ack_o(mem_d_ack_o), .mem_d_error_o(mem_d_error_o),
    .mem_d_resp_tag_o(mem_d_resp_tag_o), .console_valid_o(console_valid_o), .console_data_o(console_data_o),
    .console_ready_i(console_ready_i), .done_o(done_o), .pass_o(pass_o)
  );

  always #5 clk_i = ~clk_i;

  // reference cycle count: clocks since reset release
  always @(posedge clk_i or posedge rst_i) cyc_m <= rst_i ? 32'd0 : cyc_m + 32'd1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    mem_d_rd_i = 1'b0;
    mem_d_wr_i = 4'd0;
    {mem_d_cacheable_i, mem_d_invalidate_i, mem_d_writeback_i, mem_d_flush_i} = 4'd0;
  endtask

  // one clock: check any byte leaving the console, then the response slot
  task automatic tick();
    exp_t e;
    if (console_valid_o && console_ready_i) begin
      if (cq.size() == 0) chk("con_extra", {31'd0, console_valid_o}, 32'd0);
      else chk("con_byte", {24'd0, console_data_o}, {24'd0, cq.pop_front()});
    end
    @(negedge clk_i);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("ack", {31'd0, mem_d_ack_o}, 32'd1);
      chk("tag", {21'd0, mem_d_resp_tag_o}, {21'd0, e.tag});
      chk("err", {31'd0, mem_d_error_o}, {31'd0, e.err});
      chk("data", mem_d_data_rd_o, e.data);
    end else begin
      chk("no_ack", {31'd0, mem_d_ack_o}, 32'd0);
      chk("idle_data", mem_d_data_rd_o, 32'd0);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic rd, input logic [3:0] wr,
                       input logic [3:0] h, input logic [31:0] exp, input logic er, input logic acc);
    mem_d_addr_i = a;
    mem_d_data_wr_i = d;
    mem_d_rd_i = rd;
    mem_d_wr_i = wr;
    {mem_d_cacheable_i, mem_d_invalidate_i, mem_d_writeback_i, mem_d_flush_i} = h;
    mem_d_req_tag_i = tag_n;
    #1;
    chk("accept", {31'd0, mem_d_accept_o}, {31'd0, acc});
    if (mem_d_accept_o) begin
      sb.push_back('{tag_n, er, exp});
`ifdef DPORT_SIM_CTRL_CONSOLE_EN
      if (a == B + 32'hC && wr[0]) cq.push_back(d[7:0]);
`endif
    end
    tag_n++;
    tick();
    idle();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ack"}, {31'd0, mem_d_ack_o}, 32'd0);
    chk({tag, "_data"}, mem_d_data_rd_o, 32'd0);
    chk({tag, "_err"}, {31'd0, mem_d_error_o}, 32'd0);
    chk({tag, "_tag"}, {21'd0, mem_d_resp_tag_o}, 32'd0);
    chk({tag, "_accept"}, {31'd0, mem_d_accept_o}, 32'd0);
    chk({tag, "_cvalid"}, {31'd0, console_valid_o}, 32'd0);
    chk({tag, "_cdata"}, {24'd0, console_data_o}, 32'd0);
    chk({tag, "_done"}, {31'd0, done_o}, 32'd0);
    chk({tag, "_pass"}, {31'd0, pass_o}, 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk_i);
    #1 chk_zero("reset");
    @(negedge clk_i);
    rst_i = 1'b0;
    // scratch byte enables, back-to-back
    issue(B + 32'h8, 32'h1122_3344, 1'b0, 4'b0011, 4'd0, 32'd0, 1'b0, 1'b1);
    issue(B + 32'h8, 32'hAABB_CCDD, 1'b0, 4'b1100, 4'd0, 32'd0, 1'b0, 1'b1);
    issue(B + 32'h8, 32'd0, 1'b1, 4'd0, 4'd0, 32'hAABB_3344, 1'b0, 1'b1);
    issue(B + 32'h8, 32'h0000_0055, 1'b1, 4'b0001, 4'd0, 32'd0, 1'b0, 1'b1);
    issue(B + 32'h8, 32'd0, 1'b1, 4'd0, 4'd0, 32'hAABB_3355, 1'b0, 1'b1);
    // sticky status, byte enables ignored
    chk("done_pre", {31'd0, done_o}, 32'd0);
    issue(B, 32'h3, 1'b0, 4'b0010, 4'd0, 32'd0, 1'b0, 1'b1);
    chk("done_set", {31'd0, done_o}, 32'd1);
    chk("pass_set", {31'd0, pass_o}, 32'd1);
    issue(B, 32'h1, 1'b0, 4'b1111, 4'd0, 32'd0, 1'b0, 1'b1);
    issue(B, 32'd0, 1'b1, 4'd0, 4'd0, 32'h3, 1'b0, 1'b1);
    chk("pass_sticky", {31'd0, pass_o}, 32'd1);
    // errors, hints, read-only cycle
    issue(B + 32'h100, 32'd0, 1'b1, 4'd0, 4'd0, 32'd0, 1'b1, 1'b1);
    issue(B + 32'h1C, 32'd0, 1'b1, 4'd0, 4'd0, 32'd0, 1'b1, 1'b1);
    issue(B + 32'h2, 32'd0, 1'b1, 4'd0, 4'd0, 32'd0, 1'b1, 1'b1);
    issue(B + 32'h9, 32'hFFFF_FFFF, 1'b0, 4'b1111, 4'd0, 32'd0, 1'b1, 1'b1);
    issue(B + 32'h200, 32'd0, 1'b0, 4'd0, 4'b0001, 32'd0, 1'b0, 1'b1);
    issue(B + 32'h8, 32'd0, 1'b0, 4'd0, 4'b1000, 32'd0, 1'b0, 1'b1);
    issue(B + 32'h4, 32'd0, 1'b0, 4'b1111, 4'd0, 32'd0, 1'b0, 1'b1);
    issue(B + 32'h8, 32'd0, 1'b1, 4'd0, 4'd0, 32'hAABB_3355, 1'b0, 1'b1);
    // cycle counter spacing and wrap
    c0 = cyc_m;
    issue(B + 32'h4, 32'd0, 1'b1, 4'd0, 4'd0, c0, 1'b0, 1'b1);
    repeat (9) tick();
    issue(B + 32'h4, 32'd0, 1'b1, 4'd0, 4'd0, c0 + 32'd10, 1'b0, 1'b1);
    force dut.cycle_nxt = 32'hFFFF_FFFF;
    tick();
    release dut.cycle_nxt;
    issue(B + 32'h4, 32'd0, 1'b1, 4'd0, 4'd0, 32'hFFFF_FFFF, 1'b0, 1'b1);
    issue(B + 32'h4, 32'd0, 1'b1, 4'd0, 4'd0, 32'd0, 1'b0, 1'b1);
    // console stream
    console_ready_i = 1'b0;
`ifdef DPORT_SIM_CTRL_CONSOLE_EN
    for (int i = 0; i < 4; i++)
      issue(B + 32'hC, 32'h41 + i, 1'b0, 4'b0001, 4'd0, 32'd0, 1'b0, 1'b1);
    chk("con_valid_full", {31'd0, console_valid_o}, 32'd1);
    chk("con_head", {24'd0, console_data_o}, 32'h41);
    issue(B + 32'hC, 32'd0, 1'b1, 4'd0, 4'd0, 32'd4, 1'b0, 1'b1);
    mem_d_addr_i = B + 32'hC;
    mem_d_data_wr_i = 32'h45;
    mem_d_wr_i = 4'b0001;
    mem_d_req_tag_i = tag_n;
    #1 chk("stall_full", {31'd0, mem_d_accept_o}, 32'd0);
    tick();
    #1 chk("stall_hold", {31'd0, mem_d_accept_o}, 32'd0);
    console_ready_i = 1'b1;
    #1 chk("stall_pop_cycle", {31'd0, mem_d_accept_o}, 32'd0);
    tick();
    #1 chk("accept_after_pop", {31'd0, mem_d_accept_o}, 32'd1);
    sb.push_back('{tag_n, 1'b0, 32'd0});
    cq.push_back(8'h45);
    tag_n++;
    tick();
    idle();
    for (int i = 0; i < 8 && console_valid_o; i++) tick();
    chk("con_drained", {31'd0, console_valid_o}, 32'd0);
    console_ready_i = 1'b0;
    issue(B + 32'hC, 32'h5A, 1'b0, 4'b0010, 4'd0, 32'd0, 1'b0, 1'b1);
    chk("con_no_wr0", {31'd0, console_valid_o}, 32'd0);
    issue(B + 32'hC, 32'h46, 1'b0, 4'b0001, 4'd0, 32'd0, 1'b0, 1'b1);
    issue(B + 32'hC, 32'h47, 1'b0, 4'b0001, 4'd0, 32'd0, 1'b0, 1'b1);
    console_ready_i = 1'b1;
    issue(B + 32'hC, 32'h48, 1'b0, 4'b0001, 4'd0, 32'd0, 1'b0, 1'b1);
    console_ready_i = 1'b0;
    issue(B + 32'hC, 32'd0, 1'b1, 4'd0, 4'd0, 32'd2, 1'b0, 1'b1);
    console_ready_i = 1'b1;
    for (int i = 0; i < 8 && console_valid_o; i++) tick();
    chk("con_drained2", {31'd0, console_valid_o}, 32'd0);
`else
    for (int i = 0; i < 5; i++)
      issue(B + 32'hC, 32'h41 + i, 1'b0, 4'b0001, 4'd0, 32'd0, 1'b0, 1'b1);
    chk("con_valid_off", {31'd0, console_valid_o}, 32'd0);
    chk("con_data_off", {24'd0, console_data_o}, 32'd0);
    issue(B + 32'hC, 32'd0, 1'b1, 4'd0, 4'd0, 32'd0, 1'b0, 1'b1);
`endif
    chk("con_queue_empty", cq.size(), 32'd0);
    console_ready_i = 1'b0;
    // reset right after accepting a read drops the response
    mem_d_addr_i = B + 32'h8;
    mem_d_rd_i = 1'b1;
    mem_d_req_tag_i = tag_n;
    #1 chk("pre_rst_accept", {31'd0, mem_d_accept_o}, 32'd1);
    @(posedge clk_i);
    #1 rst_i = 1'b1;
    idle();
    @(negedge clk_i);
    #1 chk_zero("mid_rst");
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (3) tick();
    issue(B, 32'd0, 1'b1, 4'd0, 4'd0, 32'd0, 1'b0, 1'b1);
    issue(B + 32'h8, 32'd0, 1'b1, 4'd0, 4'd0, 32'd0, 1'b0, 1'b1);
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
